cv32e40p_voter_fault_manager: RTL and testbench

//  Central fault controller for the TMR pipeline voters. Aggregates per-voter correct/detect flags
//  and minority-replica IDs, tracks per-replica error rates with leaky counters, sequences
//  re-synchronisation of a repeatedly faulty replica, and disables it once recovery has failed.

---
 rtl/cv32e40p_ft_pkg.sv | 32 +++
 rtl/cv32e40p_ft_sat_counter.sv | 43 ++++
 rtl/cv32e40p_voter_fault_manager.sv | 182 ++++++++++++++++++
 tb/tb_cv32e40p_voter_fault_manager.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/cv32e40p_ft_pkg.sv
// rtl/cv32e40p_ft_pkg.sv - shared types and helpers for the TMR voter fault manager
package cv32e40p_ft_pkg;

    typedef enum logic [1:0] {
        NORMAL   = 2'd0,
        RESYNC   = 2'd1,
        DEGRADED = 2'd2,
        FATAL    = 2'd3
    } ft_state_e;

    typedef logic [1:0] replica_idx_t;

    localparam replica_idx_t REPLICA_NONE = 2'd3;
    localparam int           N_REPLICAS   = 3;

    function automatic logic [N_REPLICAS-1:0] replica_onehot(input replica_idx_t idx);
        logic [N_REPLICAS-1:0] oh;
        oh = '0;
        for (int r = 0; r < N_REPLICAS; r++) begin
            if (idx == replica_idx_t'(r)) begin
                oh[r] = 1'b1;
            end
        end
        return oh;
    endfunction

    // Two replicas blamed in one cycle means no majority was trustworthy.
    function automatic logic multi_blame(input logic [N_REPLICAS-1:0] b);
        return (b[0] & b[1]) | (b[0] & b[2]) | (b[1] & b[2]);
    endfunction

endpackage

// File: rtl/cv32e40p_ft_sat_counter.sv
// rtl/cv32e40p_ft_sat_counter.sv - saturating up/down error counter with clear
module cv32e40p_ft_sat_counter #(
    parameter int CNT_W = 4
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             clr_i,
    input  logic             inc_i,
    input  logic             dec_i,
    output logic [CNT_W-1:0] cnt_o
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i) begin
            if (cnt_q != CNT_MAX) begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end else if (dec_i) begin
            if (cnt_q != '0) begin
                cnt_d = cnt_q - CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/cv32e40p_voter_fault_manager.sv
// rtl/cv32e40p_voter_fault_manager.sv - TMR voter fault aggregation, resync sequencing and escalation
module cv32e40p_voter_fault_manager
    import cv32e40p_ft_pkg::*;
#(
    parameter int N_VOTERS     = 8,
    parameter int CNT_W        = 4,
    parameter int PERM_THRESH  = 8,
    parameter int DECAY_PERIOD = 1024,
    parameter int MAX_RESYNC   = 2
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic                        valid_i,
    input  logic [N_VOTERS-1:0]         err_correct_i,
    input  logic [N_VOTERS-1:0]         err_detect_i,
    input  logic [2*N_VOTERS-1:0]       minority_i,
    input  logic                        resync_ack_i,
    output logic                        resync_req_o,
    output logic [1:0]                  resync_id_o,
    output logic [N_REPLICAS-1:0]       disable_mask_o,
    output logic [N_REPLICAS*CNT_W-1:0] err_cnt_o,
    output logic [15:0]                 corr_total_o,
    output logic                        fatal_o,
    output logic                        halt_req_o
);

    localparam int                 ATT_W     = $clog2(MAX_RESYNC + 2);
    localparam int                 TIMER_W   = $clog2(DECAY_PERIOD);
    localparam logic [TIMER_W-1:0] TIMER_MAX = TIMER_W'(DECAY_PERIOD - 1);
    localparam logic [CNT_W-1:0]   THRESH    = CNT_W'(PERM_THRESH);
    localparam logic [ATT_W-1:0]   ATT_LIMIT = ATT_W'(MAX_RESYNC);

    ft_state_e             state_q, state_d;
    replica_idx_t          resync_id_q, resync_id_d;
    logic [ATT_W-1:0]      attempts_q [N_REPLICAS];
    logic [ATT_W-1:0]      attempts_d [N_REPLICAS];
    logic [N_REPLICAS-1:0] disable_q, disable_d;
    logic [TIMER_W-1:0]    timer_q, timer_d;
    logic [15:0]           total_q, total_d;

    logic [N_REPLICAS-1:0] blame_raw, blame, resync_sel;
    logic [N_REPLICAS-1:0] cnt_inc, cnt_clr, thr_oh;
    logic [CNT_W-1:0]      cnt [N_REPLICAS];
    logic                  blame_any, uncorr, fatal_evt, frozen, cnt_dec;
    logic                  thr_hit, thr_can_resync;
    replica_idx_t          thr_id;

    // Only minority IDs 0..2 match a replica, so REPLICA_NONE drops out naturally.
    always_comb begin
        blame_raw = '0;
        for (int v = 0; v < N_VOTERS; v++) begin
            for (int r = 0; r < N_REPLICAS; r++) begin
                if (valid_i && err_correct_i[v] && (minority_i[2*v +: 2] == replica_idx_t'(r))) begin
                    blame_raw[r] = 1'b1;
                end
            end
        end
    end

    assign resync_sel = (state_q == RESYNC) ? replica_onehot(resync_id_q) : '0;
    assign blame      = blame_raw & ~disable_q & ~resync_sel;
    assign blame_any  = |blame;

    assign uncorr    = valid_i && ((|(err_detect_i & ~err_correct_i)) ||
                                   multi_blame(blame) ||
                                   ((|err_detect_i) && (|disable_q)));
    assign fatal_evt = uncorr && (state_q != FATAL);
    assign frozen    = (state_q == FATAL) || fatal_evt;

    assign cnt_inc = frozen ? '0 : blame;
    assign cnt_dec = !frozen && !blame_any && (timer_q == TIMER_MAX);

    always_comb begin
        timer_d = timer_q + TIMER_W'(1);
        if (blame_any || (timer_q == TIMER_MAX)) begin
            timer_d = '0;
        end
        total_d = total_q;
        if (blame_any && !frozen && (total_q != 16'hFFFF)) begin
            total_d = total_q + 16'd1;
        end
    end

    // Descending scan so the lowest-numbered replica over threshold wins.
    always_comb begin
        thr_hit        = 1'b0;
        thr_id         = '0;
        thr_can_resync = 1'b0;
        for (int r = N_REPLICAS - 1; r >= 0; r--) begin
            if ((cnt[r] >= THRESH) && !disable_q[r]) begin
                thr_hit        = 1'b1;
                thr_id         = replica_idx_t'(r);
                thr_can_resync = (attempts_q[r] < ATT_LIMIT);
            end
        end
        thr_oh = replica_onehot(thr_id);
    end

    always_comb begin
        state_d     = state_q;
        resync_id_d = resync_id_q;
        attempts_d  = attempts_q;
        disable_d   = disable_q;
        cnt_clr     = '0;
        if (fatal_evt) begin
            state_d = FATAL;
        end else begin
            case (state_q)
                NORMAL: begin
                    if (thr_hit) begin
                        if (thr_can_resync) begin
                            state_d     = RESYNC;
                            resync_id_d = thr_id;
                            for (int r = 0; r < N_REPLICAS; r++) begin
                                if (thr_oh[r]) begin
                                    attempts_d[r] = attempts_q[r] + ATT_W'(1);
                                end
                            end
                        end else begin
                            state_d   = DEGRADED;
                            disable_d = disable_q | thr_oh;
                            cnt_clr   = thr_oh;
                        end
                    end
                end
                RESYNC: begin
                    if (resync_ack_i) begin
                        state_d = NORMAL;
                        cnt_clr = replica_onehot(resync_id_q);
                    end
                end
                default: begin
                    state_d = state_q;
                end
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= NORMAL;
            resync_id_q <= '0;
            disable_q   <= '0;
            timer_q     <= '0;
            total_q     <= '0;
            for (int r = 0; r < N_REPLICAS; r++) begin
                attempts_q[r] <= '0;
            end
        end else begin
            state_q     <= state_d;
            resync_id_q <= resync_id_d;
            disable_q   <= disable_d;
            timer_q     <= timer_d;
            total_q     <= total_d;
            for (int r = 0; r < N_REPLICAS; r++) begin
                attempts_q[r] <= attempts_d[r];
            end
        end
    end

    for (genvar g = 0; g < N_REPLICAS; g++) begin : g_cnt
        cv32e40p_ft_sat_counter #(
            .CNT_W(CNT_W)
        ) u_cnt (
            .clk_i (clk_i),
            .rst_i (rst_i),
            .clr_i (cnt_clr[g]),
            .inc_i (cnt_inc[g]),
            .dec_i (cnt_dec),
            .cnt_o (cnt[g])
        );
        assign err_cnt_o[g*CNT_W +: CNT_W] = cnt[g];
    end

    assign resync_req_o   = (state_q == RESYNC);
    assign resync_id_o    = resync_id_q;
    assign disable_mask_o = disable_q;
    assign corr_total_o   = total_q;
    assign fatal_o        = (state_q == FATAL);
    assign halt_req_o     = (state_q == FATAL);

endmodule

// File: tb/tb_cv32e40p_voter_fault_manager.sv
// tb/tb_cv32e40p_voter_fault_manager.sv - directed vector bench for the voter fault manager
module tb_cv32e40p_voter_fault_manager;

    localparam logic [15:0] MN_B1   = 16'hFF7F;
    localparam logic [15:0] MN_B0   = 16'hFFFC;
    localparam logic [15:0] MN_B2   = 16'hFBFF;
    localparam logic [15:0] MN_B1B1 = 16'hFF7D;
    localparam logic [15:0] MN_B0B2 = 16'hFBFC;
    localparam logic [15:0] MN_NONE = 16'hFFFF;

    logic        clk = 1'b0;
    logic        rst_i;
    logic        valid_i;
    logic [7:0]  err_correct_i;
    logic [7:0]  err_detect_i;
    logic [15:0] minority_i;
    logic        resync_ack_i;
    logic        resync_req_o;
    logic [1:0]  resync_id_o;
    logic [2:0]  disable_mask_o;
    logic [11:0] err_cnt_o;
    logic [15:0] corr_total_o;
    logic        fatal_o;
    logic        halt_req_o;

    always #5 clk = ~clk;

    cv32e40p_voter_fault_manager #(
        .N_VOTERS(8), .CNT_W(4), .PERM_THRESH(8), .DECAY_PERIOD(1024), .MAX_RESYNC(2)
    ) dut (
        .clk_i          (clk),
        .rst_i          (rst_i),
        .valid_i        (valid_i),
        .err_correct_i  (err_correct_i),
        .err_detect_i   (err_detect_i),
        .minority_i     (minority_i),
        .resync_ack_i   (resync_ack_i),
        .resync_req_o   (resync_req_o),
        .resync_id_o    (resync_id_o),
        .disable_mask_o (disable_mask_o),
        .err_cnt_o      (err_cnt_o),
        .corr_total_o   (corr_total_o),
        .fatal_o        (fatal_o),
        .halt_req_o     (halt_req_o)
    );

    typedef struct {
        logic        rst;
        logic        valid;
        logic [7:0]  corr;
        logic [7:0]  det;
        logic [15:0] mn;
        logic        ack;
        logic [11:0] cnt;
        logic [15:0] tot;
        logic        req;
        logic [1:0]  id;
        logic [2:0]  mask;
        logic        fat;
    } vec_t;

    vec_t tbl[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    function automatic vec_t mk(input logic rst, input logic valid, input logic [7:0] corr,
                                input logic [7:0] det, input logic [15:0] mn, input logic ack,
                                input logic [11:0] cnt, input logic [15:0] tot, input logic req,
                                input logic [1:0] id, input logic [2:0] mask, input logic fat);
        vec_t t;
        t.rst = rst; t.valid = valid; t.corr = corr; t.det = det; t.mn = mn; t.ack = ack;
        t.cnt = cnt; t.tot = tot; t.req = req; t.id = id; t.mask = mask; t.fat = fat;
        return t;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic apply(input logic rst, input logic valid, input logic [7:0] corr,
                         input logic [7:0] det, input logic [15:0] mn, input logic ack);
        rst_i = rst; valid_i = valid; err_correct_i = corr; err_detect_i = det;
        minority_i = mn; resync_ack_i = ack;
        @(posedge clk);
        #1;
    endtask

    task automatic check_all(input string tag, input logic [11:0] cnt, input logic [15:0] tot,
                             input logic req, input logic [1:0] id, input logic [2:0] mask,
                             input logic fat);
        chk({tag, ".err_cnt"},    32'(err_cnt_o),      32'(cnt));
        chk({tag, ".corr_total"}, 32'(corr_total_o),   32'(tot));
        chk({tag, ".resync_req"}, 32'(resync_req_o),   32'(req));
        if (req) chk({tag, ".resync_id"}, 32'(resync_id_o), 32'(id));
        chk({tag, ".disable"},    32'(disable_mask_o), 32'(mask));
        chk({tag, ".fatal"},      32'(fatal_o),        32'(fat));
        chk({tag, ".halt"},       32'(halt_req_o),     32'(fat));
    endtask

    task automatic blame1_round(input logic [3:0] c0, input logic [15:0] tot0);
        for (int i = 1; i <= 8; i++) begin
            tbl.push_back(mk(0, 1, 8'h08, 8'h08, MN_B1, 0, {4'd0, 4'(i), c0}, tot0 + 16'(i), 0, 0, 0, 0));
        end
    endtask

    initial begin
        rst_i = 1'b1; valid_i = 1'b0; err_correct_i = '0; err_detect_i = '0;
        minority_i = MN_NONE; resync_ack_i = 1'b0;

        // Resync twice, then disable on the third hit, then escalate and stay fatal.
        tbl.push_back(mk(1, 1, 8'hFF, 8'hFF, 16'h0000, 1, 12'h000, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 1, 8'hAA, 8'h55, 16'h1234, 0, 12'h000, 0, 0, 0, 0, 0));
        blame1_round(4'd0, 16'd0);
        tbl.push_back(mk(0, 0, 8'h00, 8'h00, MN_NONE, 0, 12'h080, 8, 1, 1, 0, 0));
        tbl.push_back(mk(0, 1, 8'h08, 8'h08, MN_B1,   0, 12'h080, 8, 1, 1, 0, 0));
        tbl.push_back(mk(0, 1, 8'h01, 8'h01, MN_B0,   0, 12'h081, 9, 1, 1, 0, 0));
        tbl.push_back(mk(0, 0, 8'h00, 8'h00, MN_NONE, 0, 12'h081, 9, 1, 1, 0, 0));
        tbl.push_back(mk(0, 0, 8'h00, 8'h00, MN_NONE, 0, 12'h081, 9, 1, 1, 0, 0));
        tbl.push_back(mk(0, 0, 8'h00, 8'h00, MN_NONE, 1, 12'h001, 9, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 8'h00, 8'h00, MN_NONE, 1, 12'h001, 9, 0, 0, 0, 0));
        blame1_round(4'd1, 16'd9);
        tbl.push_back(mk(0, 0, 8'h00, 8'h00, MN_NONE, 0, 12'h081, 17, 1, 1, 0, 0));
        tbl.push_back(mk(0, 0, 8'h00, 8'h00, MN_NONE, 1, 12'h001, 17, 0, 0, 0, 0));
        blame1_round(4'd1, 16'd17);
        tbl.push_back(mk(0, 0, 8'h00, 8'h00, MN_NONE, 0, 12'h001, 25, 0, 0, 3'b010, 0));
        tbl.push_back(mk(0, 1, 8'h01, 8'h01, MN_B0,   0, 12'h001, 25, 0, 0, 3'b010, 1));
        for (int i = 0; i < 100; i++) begin
            tbl.push_back(mk(0, 1, 8'hFF, 8'hFF, 16'h0000, 1, 12'h001, 25, 0, 0, 3'b010, 1));
        end

        // Single-cycle corner cases, each from a fresh reset.
        tbl.push_back(mk(1, 0, 8'h00, 8'h00, MN_NONE, 0, 12'h000, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 1, 8'h21, 8'h21, MN_B0B2, 0, 12'h000, 0, 0, 0, 0, 1));
        tbl.push_back(mk(1, 0, 8'h00, 8'h00, MN_NONE, 0, 12'h000, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 1, 8'h00, 8'h01, MN_NONE, 0, 12'h000, 0, 0, 0, 0, 1));
        tbl.push_back(mk(1, 0, 8'h00, 8'h00, MN_NONE, 0, 12'h000, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 1, 8'h09, 8'h09, MN_B1B1, 0, 12'h010, 1, 0, 0, 0, 0));
        tbl.push_back(mk(0, 1, 8'h01, 8'h01, MN_NONE, 0, 12'h010, 1, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 8'hFF, 8'hFF, MN_B1B1, 0, 12'h010, 1, 0, 0, 0, 0));
        tbl.push_back(mk(0, 1, 8'h01, 8'h01, MN_B0,   0, 12'h011, 2, 0, 0, 0, 0));

        for (int k = 0; k < tbl.size(); k++) begin
            apply(tbl[k].rst, tbl[k].valid, tbl[k].corr, tbl[k].det, tbl[k].mn, tbl[k].ack);
            check_all($sformatf("vec%0d", k), tbl[k].cnt, tbl[k].tot, tbl[k].req, tbl[k].id,
                      tbl[k].mask, tbl[k].fat);
        end

        // Leaky decay: five hits on replica 2, then quiet cycles with flags high but valid low.
        apply(1, 0, 8'h00, 8'h00, MN_NONE, 0);
        for (int i = 0; i < 5; i++) apply(0, 1, 8'h20, 8'h20, MN_B2, 0);
        check_all("decay.start", 12'h500, 5, 0, 0, 0, 0);
        for (int i = 0; i < 1023; i++) apply(0, 0, 8'hFF, 8'hFF, 16'h0000, 0);
        check_all("decay.pre1", 12'h500, 5, 0, 0, 0, 0);
        apply(0, 0, 8'hFF, 8'hFF, 16'h0000, 0);
        check_all("decay.1", 12'h400, 5, 0, 0, 0, 0);
        for (int i = 0; i < 1023; i++) apply(0, 0, 8'hFF, 8'hFF, 16'h0000, 0);
        check_all("decay.pre2", 12'h400, 5, 0, 0, 0, 0);
        apply(0, 0, 8'hFF, 8'hFF, 16'h0000, 0);
        check_all("decay.2", 12'h300, 5, 0, 0, 0, 0);

        // Reset mid-handshake clears the request and the attempt history.
        apply(1, 0, 8'h00, 8'h00, MN_NONE, 0);
        for (int i = 0; i < 8; i++) apply(0, 1, 8'h08, 8'h08, MN_B1, 0);
        apply(0, 0, 8'h00, 8'h00, MN_NONE, 0);
        check_all("rsths.req", 12'h080, 8, 1, 1, 0, 0);
        apply(1, 0, 8'h00, 8'h00, MN_NONE, 0);
        check_all("rsths.rst", 12'h000, 0, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            apply(0, 0, 8'h00, 8'h00, MN_NONE, 1);
            check_all("rsths.ack", 12'h000, 0, 0, 0, 0, 0);
        end
        for (int round = 0; round < 2; round++) begin
            for (int i = 0; i < 8; i++) apply(0, 1, 8'h08, 8'h08, MN_B1, 0);
            apply(0, 0, 8'h00, 8'h00, MN_NONE, 0);
            check_all($sformatf("rsths.round%0d", round), 12'h080, 16'(8 * (round + 1)), 1, 1, 0, 0);
            apply(0, 0, 8'h00, 8'h00, MN_NONE, 1);
            check_all($sformatf("rsths.done%0d", round), 12'h000, 16'(8 * (round + 1)), 0, 0, 0, 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
